// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-phase accumulator CPU: opcodes and phase numbers.
package cpu_pkg;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [2:0] PHASE_INST_ADDR  = 3'd0;
   localparam logic [2:0] PHASE_INST_FETCH = 3'd1;
   localparam logic [2:0] PHASE_INST_LOAD  = 3'd2;
   localparam logic [2:0] PHASE_IDLE       = 3'd3;
   localparam logic [2:0] PHASE_OP_ADDR    = 3'd4;
   localparam logic [2:0] PHASE_OP_FETCH   = 3'd5;
   localparam logic [2:0] PHASE_ALU_OP     = 3'd6;
   localparam logic [2:0] PHASE_STORE      = 3'd7;

   // Datapath strobes in bus order {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic halt;
      logic ld_pc;
      logic data_e;
      logic ld_ac;
      logic wr;
   } strobes_t;

endpackage

// File: rtl/controller.sv
// Instruction-sequencing decoder: combinational strobe decode per phase plus a
// sticky registered halt status.
//
// phase | meaning
// ------+-------------------------------------------------------------
//   0   | INST_ADDR  - PC drives the address bus
//   1   | INST_FETCH - read instruction from memory
//   2   | INST_LOAD  - latch instruction into IR
//   3   | IDLE       - hold fetch strobes while IR settles
//   4   | OP_ADDR    - advance PC, flag HLT
//   5   | OP_FETCH   - read operand for ALU-type instructions
//   6   | ALU_OP     - conditional skip, jump, store data drive
//   7   | STORE      - accumulator load, jump, memory write
module controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic [2:0] phase,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr,
   output logic       halted
);

   strobes_t dec;
   strobes_t strb;
   logic     alu_op;

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

   // Phase decode qualified by opcode; zero only matters for SKZ in ALU_OP
   always_comb begin
      dec = '0;
      case (phase)
         PHASE_INST_ADDR: begin
            dec.sel = 1'b1;
         end
         PHASE_INST_FETCH: begin
            dec.sel = 1'b1;
            dec.rd  = 1'b1;
         end
         PHASE_INST_LOAD, PHASE_IDLE: begin
            dec.sel   = 1'b1;
            dec.rd    = 1'b1;
            dec.ld_ir = 1'b1;
         end
         PHASE_OP_ADDR: begin
            dec.inc_pc = 1'b1;
            dec.halt   = (opcode == OP_HLT);
         end
         PHASE_OP_FETCH: begin
            dec.rd = alu_op;
         end
         PHASE_ALU_OP: begin
            dec.rd     = alu_op;
            dec.inc_pc = (opcode == OP_SKZ) && zero;
            dec.ld_pc  = (opcode == OP_JMP);
            dec.data_e = (opcode == OP_STO);
         end
         PHASE_STORE: begin
            dec.rd     = alu_op;
            dec.ld_ac  = alu_op;
            dec.ld_pc  = (opcode == OP_JMP);
            dec.data_e = (opcode == OP_STO);
            dec.wr     = (opcode == OP_STO);
         end
         default: dec = '0;
      endcase
   end

   // Reset forces every strobe low regardless of the decode
   always_comb begin
      strb = rst ? '0 : dec;
   end

   assign sel    = strb.sel;
   assign rd     = strb.rd;
   assign ld_ir  = strb.ld_ir;
   assign inc_pc = strb.inc_pc;
   assign halt   = strb.halt;
   assign ld_pc  = strb.ld_pc;
   assign data_e = strb.data_e;
   assign ld_ac  = strb.ld_ac;
   assign wr     = strb.wr;

   // Sticky halt status: reset clears, halt strobe sets, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         halted <= 1'b0;
      end else if (strb.halt) begin
         halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_controller.sv
// Directed bench for the phase decoder and the sticky halted flag.
module tb_controller;
   import cpu_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] opcode;
   logic [2:0] phase;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic       halted;
   logic [8:0] strobes;

   int checks;
   int failures;

   controller dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .phase  (phase),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .halt   (halt),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .halted (halted)
   );

   assign strobes = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_strobes(input string tag, input logic [8:0] expected);
      checks++;
      assert (strobes === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%09b expected=%09b", tag, strobes, expected);
      end
   endtask

   task automatic check_halted(input string tag, input logic expected);
      checks++;
      assert (halted === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, halted, expected);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [2:0] ph, input logic z);
      opcode = op;
      phase  = ph;
      zero   = z;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      opcode   = OP_HLT;
      phase    = PHASE_OP_ADDR;
      zero     = 1'b0;

      // Reset with HLT in OP_ADDR: reset masks halt and wins over it
      #1;
      check_strobes("rst_hlt_p4_strobes", 9'b000000000);
      @(posedge clk); #1;
      check_halted("rst_hlt_halted", 1'b0);
      drive(OP_STO, PHASE_STORE, 1'b1);
      check_strobes("rst_sto_p7_strobes", 9'b000000000);
      drive(OP_ADD, PHASE_INST_LOAD, 1'b0);
      check_strobes("rst_add_p2_strobes", 9'b000000000);
      @(posedge clk); #1;
      check_halted("rst_hold_halted", 1'b0);

      // Release reset, ADD phases do not set halted
      rst = 1'b0;
      drive(OP_ADD, PHASE_INST_ADDR, 1'b0);
      @(posedge clk); #1;
      check_halted("no_halt_halted", 1'b0);

      // HLT sweep
      drive(OP_HLT, 3'd0, 1'b0); check_strobes("hlt_p0", 9'b100000000);
      drive(OP_HLT, 3'd1, 1'b0); check_strobes("hlt_p1", 9'b110000000);
      drive(OP_HLT, 3'd2, 1'b0); check_strobes("hlt_p2", 9'b111000000);
      drive(OP_HLT, 3'd3, 1'b0); check_strobes("hlt_p3", 9'b111000000);
      drive(OP_HLT, 3'd5, 1'b0); check_strobes("hlt_p5", 9'b000000000);
      drive(OP_HLT, 3'd6, 1'b1); check_strobes("hlt_p6_z1", 9'b000000000);
      drive(OP_HLT, 3'd7, 1'b0); check_strobes("hlt_p7", 9'b000000000);

      // SKZ: conditional skip only in phase 6
      drive(OP_SKZ, 3'd4, 1'b0); check_strobes("skz_p4", 9'b000100000);
      drive(OP_SKZ, 3'd5, 1'b0); check_strobes("skz_p5", 9'b000000000);
      drive(OP_SKZ, 3'd6, 1'b0); check_strobes("skz_p6_z0", 9'b000000000);
      drive(OP_SKZ, 3'd7, 1'b0); check_strobes("skz_p7_z0", 9'b000000000);
      drive(OP_SKZ, 3'd6, 1'b1); check_strobes("skz_p6_z1", 9'b000100000);
      drive(OP_SKZ, 3'd7, 1'b1); check_strobes("skz_p7_z1", 9'b000000000);
      drive(OP_SKZ, 3'd0, 1'b1); check_strobes("skz_p0_z1", 9'b100000000);

      // ALU-type opcodes
      drive(OP_ADD, 3'd4, 1'b0); check_strobes("add_p4", 9'b000100000);
      drive(OP_ADD, 3'd5, 1'b0); check_strobes("add_p5", 9'b010000000);
      drive(OP_ADD, 3'd6, 1'b1); check_strobes("add_p6_z1", 9'b010000000);
      drive(OP_ADD, 3'd7, 1'b1); check_strobes("add_p7_z1", 9'b010000010);
      drive(OP_AND, 3'd4, 1'b0); check_strobes("and_p4", 9'b000100000);
      drive(OP_AND, 3'd5, 1'b0); check_strobes("and_p5", 9'b010000000);
      drive(OP_AND, 3'd6, 1'b0); check_strobes("and_p6", 9'b010000000);
      drive(OP_AND, 3'd7, 1'b0); check_strobes("and_p7", 9'b010000010);
      drive(OP_XOR, 3'd4, 1'b0); check_strobes("xor_p4", 9'b000100000);
      drive(OP_XOR, 3'd5, 1'b0); check_strobes("xor_p5", 9'b010000000);
      drive(OP_XOR, 3'd6, 1'b0); check_strobes("xor_p6", 9'b010000000);
      drive(OP_XOR, 3'd7, 1'b0); check_strobes("xor_p7", 9'b010000010);
      drive(OP_LDA, 3'd4, 1'b0); check_strobes("lda_p4", 9'b000100000);
      drive(OP_LDA, 3'd5, 1'b0); check_strobes("lda_p5", 9'b010000000);
      drive(OP_LDA, 3'd6, 1'b0); check_strobes("lda_p6", 9'b010000000);
      drive(OP_LDA, 3'd7, 1'b0); check_strobes("lda_p7", 9'b010000010);

      // STO
      drive(OP_STO, 3'd4, 1'b0); check_strobes("sto_p4", 9'b000100000);
      drive(OP_STO, 3'd5, 1'b0); check_strobes("sto_p5", 9'b000000000);
      drive(OP_STO, 3'd6, 1'b0); check_strobes("sto_p6", 9'b000000100);
      drive(OP_STO, 3'd7, 1'b0); check_strobes("sto_p7", 9'b000000101);

      // JMP
      drive(OP_JMP, 3'd4, 1'b0); check_strobes("jmp_p4", 9'b000100000);
      drive(OP_JMP, 3'd5, 1'b0); check_strobes("jmp_p5", 9'b000000000);
      drive(OP_JMP, 3'd6, 1'b1); check_strobes("jmp_p6", 9'b000001000);
      drive(OP_JMP, 3'd7, 1'b0); check_strobes("jmp_p7", 9'b000001000);
      drive(OP_JMP, 3'd3, 1'b0); check_strobes("jmp_p3", 9'b111000000);

      // halted: still clear, then HLT in OP_ADDR sets it on the next edge
      @(posedge clk); #1;
      check_halted("pre_hlt_halted", 1'b0);
      drive(OP_HLT, PHASE_OP_ADDR, 1'b0);
      check_strobes("hlt_p4", 9'b000110000);
      check_halted("hlt_p4_before_edge", 1'b0);
      @(posedge clk); #1;
      check_halted("hlt_set_halted", 1'b1);

      // Holds through phase and opcode changes
      drive(OP_ADD, PHASE_OP_FETCH, 1'b0);
      @(posedge clk); #1;
      check_halted("hold_p5_halted", 1'b1);
      drive(OP_HLT, PHASE_INST_ADDR, 1'b0);
      check_strobes("halted_no_gate_p0", 9'b100000000);
      @(posedge clk); #1;
      check_halted("hold_p0_halted", 1'b1);

      // Reset clears it
      rst = 1'b1;
      #1;
      check_strobes("rst_again_strobes", 9'b000000000);
      check_halted("rst_again_before_edge", 1'b1);
      @(posedge clk); #1;
      check_halted("rst_again_halted", 1'b0);
      rst = 1'b0;
      drive(OP_JMP, PHASE_ALU_OP, 1'b0);
      @(posedge clk); #1;
      check_halted("post_rst_halted", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
